// File: rtl/mips_mem_arb_pkg.sv
// rtl/mips_mem_arb_pkg.sv - Shared types and constants for the unified-memory arbiter
package mips_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;
    localparam logic [3:0]  FETCH_BE      = 4'hF;

endpackage

// File: rtl/mips_rr_arb2.sv
// rtl/mips_rr_arb2.sv - Two-way round-robin picker between fetch and data requests
module mips_rr_arb2
    import mips_mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  grant_t last_grant_i,
    output logic   grant_valid_o,
    output grant_t grant_o
);

    // A lone request wins outright; a tie goes to the port that did not win last.
    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_o       = INSTR;
        if (i_req_i && d_req_i) begin
            grant_o = (last_grant_i == DATA) ? INSTR : DATA;
        end else if (d_req_i) begin
            grant_o = DATA;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - Fetch/data arbiter onto one memory port; MEM_ARB_TIMEOUT_EN adds a waitrequest timeout
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [3:0]        d_byteenable,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_byteenable,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err
);

    // A zero limit would abort before a single wait cycle could be counted.
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("MAX_WAIT must be at least 1");
    end

    arb_state_t        state_q, state_d;
    grant_t            grant_q, grant_d;
    grant_t            last_grant_q, last_grant_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;

    logic              arb_valid;
    grant_t            arb_grant;
    logic              timeout;
    logic              cmd_done;
    logic [DATA_W-1:0] cmd_rdata;

    mips_rr_arb2 u_rr_arb2 (
        .i_req_i       (i_req),
        .d_req_i       (d_req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (arb_valid),
        .grant_o       (arb_grant)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WAIT_W = (MAX_WAIT > 255) ? $clog2(MAX_WAIT + 1) : 8;

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    // Abort on the cycle that would be the MAX_WAIT-th consecutive stall.
    assign timeout = (state_q == CMD) && m_waitrequest &&
                     (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));
    assign err     = err_q;

    // Stall counter restarts for every command; err latches the first abort.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        if (state_q != CMD) begin
            wait_cnt_d = '0;
        end else if (m_waitrequest) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Sequence IDLE -> CMD -> RESP: grant and register the command, wait out the
    // stall, then pulse the winner's ack while the requests are ignored.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_read_d     = m_read_q;
        m_write_d    = m_write_q;
        m_addr_d     = m_addr_q;
        m_be_d       = m_be_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        cmd_done     = 1'b0;
        cmd_rdata    = m_rdata;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = CMD;
                    if (arb_grant == INSTR) begin
                        m_read_d  = 1'b1;
                        m_write_d = 1'b0;
                        m_addr_d  = i_addr;
                        m_be_d    = FETCH_BE;
                        m_wdata_d = '0;
                    end else begin
                        m_read_d  = ~d_write;
                        m_write_d = d_write;
                        m_addr_d  = d_addr;
                        m_be_d    = d_byteenable;
                        m_wdata_d = d_wdata;
                    end
                end
            end
            CMD: begin
                if (!m_waitrequest) begin
                    cmd_done = 1'b1;
                end else if (timeout) begin
                    cmd_done  = 1'b1;
                    cmd_rdata = DATA_W'(TIMEOUT_RDATA);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cmd_done) begin
            state_d      = RESP;
            m_read_d     = 1'b0;
            m_write_d    = 1'b0;
            last_grant_d = grant_q;
            if (grant_q == INSTR) begin
                i_rdata_d = cmd_rdata;
                i_ack_d   = 1'b1;
            end else begin
                if (!m_write_q) begin
                    d_rdata_d = cmd_rdata;
                end
                d_ack_d = 1'b1;
            end
        end
    end

    // Main state registers; reset drops any command in flight without an ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= INSTR;
            last_grant_q <= DATA;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            m_addr_q     <= '0;
            m_be_q       <= '0;
            m_wdata_q    <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            m_addr_q     <= m_addr_d;
            m_be_q       <= m_be_d;
            m_wdata_q    <= m_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign m_read       = m_read_q;
    assign m_write      = m_write_q;
    assign m_addr       = m_addr_q;
    assign m_byteenable = m_be_q;
    assign m_wdata      = m_wdata_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign i_ack        = i_ack_q;
    assign d_ack        = d_ack_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - Directed and randomized bench for mips_mem_arbiter (honours MEM_ARB_TIMEOUT_EN)
module tb_mips_mem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_write = 1'b0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, d_ack, m_read, m_write, err;
    logic [3:0]  m_byteenable;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_write(d_write), .d_byteenable(d_byteenable),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
        .m_byteenable(m_byteenable), .m_wdata(m_wdata),
        .m_waitrequest(m_waitrequest), .m_rdata(m_rdata), .err(err)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    // Transaction-level reference: the access in flight, who won last, and what
    // each port should currently show.
    bit          t_active;
    bit          t_is_d;
    bit          t_write;
    logic [31:0] t_addr;
    logic [3:0]  t_be;
    logic [31:0] t_wdata;
    int          t_waits;
    bit          last_was_d;
    bit          e_i_ack, e_d_ack, e_err;
    logic [31:0] e_i_rdata, e_d_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        t_active   = 1'b0;
        t_is_d     = 1'b0;
        t_write    = 1'b0;
        t_addr     = '0;
        t_be       = '0;
        t_wdata    = '0;
        t_waits    = 0;
        last_was_d = 1'b1;
        e_i_ack    = 1'b0;
        e_d_ack    = 1'b0;
        e_err      = 1'b0;
        e_i_rdata  = '0;
        e_d_rdata  = '0;
    endfunction

    // Advance the reference by one clock using the inputs currently applied.
    function automatic void model_step();
        bit          resp_slot;
        bit          abort;
        logic [31:0] data;
        resp_slot = e_i_ack | e_d_ack;
        e_i_ack   = 1'b0;
        e_d_ack   = 1'b0;
        abort     = 1'b0;
        if (t_active) begin
            if (m_waitrequest) begin
                t_waits++;
`ifdef MEM_ARB_TIMEOUT_EN
                abort = (t_waits == MAXW);
`endif
            end
            if (!m_waitrequest || abort) begin
                data = abort ? 32'hDEADBEEF : m_rdata;
                if (!t_is_d) e_i_rdata = data;
                else if (!t_write) e_d_rdata = data;
                if (abort) e_err = 1'b1;
                t_active   = 1'b0;
                last_was_d = t_is_d;
                if (t_is_d) e_d_ack = 1'b1;
                else e_i_ack = 1'b1;
            end
        end else if (!resp_slot && (i_req || d_req)) begin
            t_is_d   = (i_req && d_req) ? !last_was_d : d_req;
            t_active = 1'b1;
            t_waits  = 0;
            t_write  = t_is_d && d_write;
            t_addr   = t_is_d ? d_addr : i_addr;
            t_be     = t_is_d ? d_byteenable : 4'hF;
            t_wdata  = d_wdata;
        end
    endfunction

    task automatic compare();
        chk("m_read", {31'd0, m_read}, {31'd0, t_active && !t_write});
        chk("m_write", {31'd0, m_write}, {31'd0, t_active && t_write});
        chk("rw_exclusive", {31'd0, m_read & m_write}, 32'd0);
        if (t_active) begin
            chk("m_addr", m_addr, t_addr);
            chk("m_byteenable", {28'd0, m_byteenable}, {28'd0, t_be});
            if (t_write) chk("m_wdata", m_wdata, t_wdata);
        end
        chk("i_ack", {31'd0, i_ack}, {31'd0, e_i_ack});
        chk("d_ack", {31'd0, d_ack}, {31'd0, e_d_ack});
        chk("i_rdata", i_rdata, e_i_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("err", {31'd0, err}, {31'd0, e_err});
    endtask

    // One clock: reference consumes the applied inputs, DUT is checked mid-cycle.
    task automatic step();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic rand_inputs();
        if (e_i_ack) i_req = 1'b0;
        else if (!i_req && $urandom_range(0, 1) == 1) begin
            i_req  = 1'b1;
            i_addr = $urandom() & 32'hFFFF_FFFC;
        end else if (i_req && $urandom_range(0, 99) == 0) i_req = 1'b0;
        if (e_d_ack) d_req = 1'b0;
        else if (!d_req && $urandom_range(0, 1) == 1) begin
            d_req        = 1'b1;
            d_write      = 1'($urandom_range(0, 1));
            d_addr       = $urandom();
            d_wdata      = $urandom();
            d_byteenable = 4'($urandom_range(1, 15));
        end else if (d_req && $urandom_range(0, 99) == 0) d_req = 1'b0;
        m_waitrequest = ($urandom_range(0, 9) < 3);
        m_rdata       = $urandom();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk("reset m_read", {31'd0, m_read}, 32'd0);
        chk("reset i_ack", {31'd0, i_ack}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        do_reset();
        compare();

        // Zero-wait fetch.
        i_req = 1'b1; i_addr = 32'hBFC00000; m_waitrequest = 1'b0; m_rdata = 32'h24420008;
        step();
        chk("fetch m_read N+1", {31'd0, m_read}, 32'd1);
        chk("fetch be N+1", {28'd0, m_byteenable}, 32'hF);
        chk("fetch addr N+1", m_addr, 32'hBFC00000);
        step();
        chk("fetch ack N+2", {31'd0, i_ack}, 32'd1);
        chk("fetch rdata", i_rdata, 32'h24420008);
        i_req = 1'b0;
        step();

        // Data write stalled for two cycles.
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h00001000; d_wdata = 32'hCAFEF00D;
        d_byteenable = 4'h3; m_waitrequest = 1'b1; m_rdata = 32'h11111111;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) m_waitrequest = 1'b1;
            step();
            chk("write m_write held", {31'd0, m_write}, 32'd1);
            chk("write no early ack", {31'd0, d_ack}, 32'd0);
        end
        m_waitrequest = 1'b0;
        step();
        chk("write ack N+4", {31'd0, d_ack}, 32'd1);
        chk("write d_rdata kept", d_rdata, 32'd0);
        d_req = 1'b0; d_write = 1'b0;
        step();

        // Both requests held from reset: strict alternation starting with the fetch.
        do_reset();
        i_req = 1'b1; i_addr = 32'h00400000; d_req = 1'b1; d_addr = 32'h10010000;
        d_byteenable = 4'hF; m_waitrequest = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            m_rdata = $urandom();
            step();
            chk("rr i_ack", {31'd0, i_ack}, {31'd0, (k % 6) == 2});
            chk("rr d_ack", {31'd0, d_ack}, {31'd0, (k % 6) == 5});
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Reset while a stalled fetch is on the bus.
        i_req = 1'b1; i_addr = 32'h00400010; m_waitrequest = 1'b1;
        step();
        chk("pre-reset m_read", {31'd0, m_read}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async drop m_read", {31'd0, m_read}, 32'd0);
        chk("async no ack", {31'd0, i_ack}, 32'd0);
        model_reset();
        @(negedge clk);
        compare();
        reset = 1'b1; m_waitrequest = 1'b0; m_rdata = 32'h8FBF0014;
        step();
        step();
        chk("post-reset fetch ack", {31'd0, i_ack}, 32'd1);
        chk("post-reset fetch data", i_rdata, 32'h8FBF0014);
        i_req = 1'b0;
        step();

        // Data read against a memory that never releases waitrequest.
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h00002000; d_byteenable = 4'hF;
        m_waitrequest = 1'b1; m_rdata = 32'h55555555;
        step();
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= MAXW; k++) step();
        chk("timeout ack", {31'd0, d_ack}, 32'd1);
        chk("timeout rdata", d_rdata, 32'hDEADBEEF);
        chk("timeout err", {31'd0, err}, 32'd1);
        d_req = 1'b0; m_waitrequest = 1'b0;
        step();
        step();
        chk("err sticky", {31'd0, err}, 32'd1);
        do_reset();
        compare();
        chk("err cleared", {31'd0, err}, 32'd0);
`else
        for (int k = 1; k <= 300; k++) step();
        chk("stall m_read held", {31'd0, m_read}, 32'd1);
        chk("stall no ack", {31'd0, d_ack}, 32'd0);
        chk("stall err low", {31'd0, err}, 32'd0);
        m_waitrequest = 1'b0;
        step();
        chk("stall release ack", {31'd0, d_ack}, 32'd1);
        chk("stall release data", d_rdata, 32'h55555555);
        d_req = 1'b0;
        step();
`endif

        // Randomized traffic from both requesters against a random-latency memory.
        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
